// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - ALU control encodings and mult/div FSM states
// Shared with ALU control, the ALU and the control unit.
package mult_div_unit_pkg;

  localparam logic [4:0] OPMULT  = 5'b10000;
  localparam logic [4:0] OPMULTU = 5'b10001;
  localparam logic [4:0] OPDIV   = 5'b10010;
  localparam logic [4:0] OPDIVU  = 5'b10011;
  localparam logic [4:0] OPMTHI  = 5'b10100;
  localparam logic [4:0] OPMTLO  = 5'b10101;
  localparam logic [4:0] OPMFHI  = 5'b10110;
  localparam logic [4:0] OPMFLO  = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one restoring-division quotient bit
// Shifts the next dividend bit into the partial remainder and trial-subtracts the divisor.
module div_restoring_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    // rem < divisor keeps shifted < 2*divisor, so bit WIDTH is a clean borrow flag
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit
// Magnitude shift-add multiply and restoring divide, signs fixed up in a final cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [4:0]       iALUCtrl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic [WIDTH-1:0] oResult
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q, neg_r, div_zero, is_mul_q, done;
  logic [WIDTH-1:0]   hi, lo;

  logic             is_mul, is_div, signed_op, start_md, last_iter;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    is_mul    = (iALUCtrl == OPMULT) || (iALUCtrl == OPMULTU);
    is_div    = (iALUCtrl == OPDIV)  || (iALUCtrl == OPDIVU);
    signed_op = (iALUCtrl == OPMULT) || (iALUCtrl == OPDIV);
    start_md  = iStart && (state_q == ST_IDLE) && (is_mul || is_div);
    a_neg     = signed_op && iA[WIDTH-1];
    b_neg     = signed_op && iB[WIDTH-1];
    a_mag     = a_neg ? -iA : iA;
    b_mag     = b_neg ? -iB : iB;
    last_iter = (cnt == CW'(WIDTH - 1));
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  end

  // Divide keeps the remainder in the upper half and shifts quotient bits into the lower half.
  div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (prod[2*WIDTH-1:WIDTH]),
    .dividend_bit (prod[WIDTH-1]),
    .divisor      (opnd),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_comb begin
    prod_neg = -prod;
    fix_hi   = '0;
    fix_lo   = '0;
    if (is_mul_q) begin
      {fix_hi, fix_lo} = neg_q ? prod_neg : prod;
    end else begin
      fix_hi = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      fix_lo = div_zero ? '1 : (neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_md) state_d = is_mul ? ST_MUL : ST_DIV;
      ST_MUL:  if (last_iter) state_d = ST_FIX;
      ST_DIV:  if (last_iter) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt      <= '0;
      prod     <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      is_mul_q <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_md) begin
            cnt      <= '0;
            opnd     <= is_mul ? a_mag : b_mag;
            prod     <= {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (iB == '0);
            is_mul_q <= is_mul;
          end else if (iStart && iALUCtrl == OPMTHI) begin
            hi <= iA;
          end else if (iStart && iALUCtrl == OPMTLO) begin
            lo <= iA;
          end
        end
        ST_MUL: begin
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
        end
        ST_DIV: begin
          prod <= {rem_next, prod[WIDTH-2:0], q_bit};
          cnt  <= cnt + 1'b1;
        end
        ST_FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    oBusy = (state_q != ST_IDLE);
    oDone = done;
    oHI   = hi;
    oLO   = lo;
    case (iALUCtrl)
      OPMFHI:  oResult = hi;
      OPMFLO:  oResult = lo;
      default: oResult = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic [4:0]  iALUCtrl = 5'd0;
  logic [31:0] iA = '0;
  logic [31:0] iB = '0;
  logic        oBusy, oDone;
  logic [31:0] oHI, oLO, oResult;

  int total = 0;
  int bad = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iALUCtrl(iALUCtrl),
    .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone),
    .oHI(oHI), .oLO(oLO), .oResult(oResult)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a start strobe across one rising edge; returns at the following negedge.
  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    iStart = 1'b1; iALUCtrl = op; iA = a; iB = b;
    @(negedge iCLK);
    iStart = 1'b0;
  endtask

  // Counts rising edges until oDone is seen, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!oDone && edges < 60) begin
      @(negedge iCLK);
      edges++;
    end
  endtask

  task automatic do_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    start_op(op, a, b);
    chk({tag, "_busy"}, 64'(oBusy), 64'd1);
    wait_done(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_hi"}, 64'(oHI), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(oLO), 64'(exp_lo));
    chk({tag, "_idle"}, 64'(oBusy), 64'd0);
    @(negedge iCLK);
    chk({tag, "_done_pulse"}, 64'(oDone), 64'd0);
  endtask

  initial begin
    int lat;
    @(negedge iCLK);
    @(negedge iCLK);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_done", 64'(oDone), 64'd0);
    chk("rst_hi", 64'(oHI), 64'd0);
    chk("rst_lo", 64'(oLO), 64'd0);
    iRST = 1'b0;
    @(negedge iCLK);

    do_md("mult_neg3x7", OPMULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_md("multu_max", OPMULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_md("mult_neg5xneg6", OPMULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h0000_001E);
    do_md("div_neg7by2", OPDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_md("div_7byneg2", OPDIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    do_md("divu_7by2", OPDIVU, 32'd7, 32'd2, 32'h1, 32'h3);
    do_md("divu_by0", OPDIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    do_md("div_min_by_neg1", OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // MTHI / MTLO / MFHI / MFLO
    start_op(OPMTHI, 32'hA5A5_A5A5, 32'd0);
    chk("mthi_busy", 64'(oBusy), 64'd0);
    chk("mthi_hi", 64'(oHI), 64'hA5A5_A5A5);
    iALUCtrl = OPMFHI;
    #1;
    chk("mfhi_result", 64'(oResult), 64'hA5A5_A5A5);
    start_op(OPMTLO, 32'h5A5A_0F0F, 32'd0);
    chk("mtlo_busy", 64'(oBusy), 64'd0);
    chk("mtlo_lo", 64'(oLO), 64'h5A5A_0F0F);
    chk("mtlo_hi_kept", 64'(oHI), 64'hA5A5_A5A5);
    iALUCtrl = OPMFLO;
    #1;
    chk("mflo_result", 64'(oResult), 64'h5A5A_0F0F);
    iALUCtrl = OPMULTU;
    #1;
    chk("result_other", 64'(oResult), 64'd0);

    // Unknown code with iStart
    start_op(5'b00000, 32'hDEAD_BEEF, 32'd1);
    chk("unk_busy", 64'(oBusy), 64'd0);
    chk("unk_hi", 64'(oHI), 64'hA5A5_A5A5);
    chk("unk_lo", 64'(oLO), 64'h5A5A_0F0F);

    // New start while busy is ignored; HI holds until the result lands
    start_op(OPMULT, 32'd2, 32'd3);
    iStart = 1'b1; iALUCtrl = OPMULTU; iA = 32'd100; iB = 32'd100;
    @(negedge iCLK);
    iStart = 1'b0;
    chk("busy_hi_held", 64'(oHI), 64'hA5A5_A5A5);
    wait_done(lat);
    chk("busy_ign_latency", 64'(lat), 64'd32);
    chk("busy_ign_hi", 64'(oHI), 64'd0);
    chk("busy_ign_lo", 64'(oLO), 64'd6);

    // Back-to-back: start accepted in the cycle oDone is high
    @(negedge iCLK);
    start_op(OPDIVU, 32'd100, 32'd7);
    wait_done(lat);
    chk("b2b_div_hi", 64'(oHI), 64'd2);
    chk("b2b_div_lo", 64'(oLO), 64'd14);
    start_op(OPMULTU, 32'd5, 32'd5);
    chk("b2b_busy", 64'(oBusy), 64'd1);
    wait_done(lat);
    chk("b2b_latency", 64'(lat), 64'd33);
    chk("b2b_lo", 64'(oLO), 64'd25);
    @(negedge iCLK);

    // Reset mid-division
    start_op(OPDIV, 32'd1000, 32'd3);
    repeat (9) @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("midrst_busy", 64'(oBusy), 64'd0);
    chk("midrst_hi", 64'(oHI), 64'd0);
    chk("midrst_lo", 64'(oLO), 64'd0);
    chk("midrst_done", 64'(oDone), 64'd0);
    iRST = 1'b0;
    repeat (40) begin
      @(negedge iCLK);
      if (oDone || oBusy) break;
    end
    chk("midrst_quiet_done", 64'(oDone), 64'd0);
    chk("midrst_quiet_busy", 64'(oBusy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
